landscape_phase_seq: RTL
========================

Name: landscape_phase_seq

Overview:
Sequences the processing window that follows ISI recording in the landscape-sampling datapath. On a start pulse it walks through the phases in order: accumulator clear, ISI-histogram sweep, pair-matrix sweep, scale steps, and result read-out. It drives the RAM address, read/write strobes and handshakes for each phase. It sits between the window controller (start on entry to idle) and the histogram/pair RAMs and scale unit.

Parameters:
bit_isi, 8, ISI bin address width; histogram sweep length 2**bit_isi
bit_addr, 9, neuron address width; pair sweep length 2**(2*bit_addr)
sb_r_min, 3, minimum scale bit; scale step count N_SCALE = 2*bit_addr - sb_r_min + 1
RD_LAT, 3, RAM read-modify-write pipeline latency in cycles (>=1)

Ports:
clk_main  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin the sequence; honoured only when busy=0
abort  in  1  synchronous abort; returns to idle
scale_ack  in  1  scale unit finished current step
out_ready  in  1  downstream accepts the current read-out word
busy  out  1  high from the cycle after an accepted start until done/abort
phase  out  3  0 idle, 1 clr, 2 hist, 3 pair, 4 scale, 5 out, 6 done
addr  out  ADDR_W  read address; ADDR_W = max(2*bit_addr, bit_isi+1, bit_addr+1)
rd_en  out  1  read strobe, hist/pair sweeps
wr_en  out  1  write-back strobe = rd_en delayed RD_LAT cycles
wr_addr  out  ADDR_W  addr delayed RD_LAT cycles
clr_acc  out  1  clear accumulators, one cycle
scale_req  out  1  scale step request
scale_idx  out  $clog2(N_SCALE+1)  current scale step
out_valid  out  1  read-out word valid at addr
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, phase=0, wr_en/wr_addr pipeline cleared. Every output is registered.
- IDLE: start=1 -> CLR on the next cycle. start is ignored in any other state.
- CLR: 1 cycle with clr_acc=1 -> HIST.
- HIST: addr runs 0..2**bit_isi-1, one per cycle, rd_en=1 -> DRAIN.
- DRAIN: RD_LAT cycles with rd_en=0. phase keeps the preceding value. Goes to PAIR after a HIST drain and to SCALE after a PAIR drain.
- PAIR: addr runs 0..2**(2*bit_addr)-1, one per cycle, rd_en=1 -> DRAIN.
- SCALE: scale_req=1 with scale_idx=k, starting at k=0.
  - A step completes in the cycle where scale_req and scale_ack are both 1. k then increments the next cycle; scale_req stays high.
  - After step N_SCALE-1 completes -> OUT with scale_req=0.
  - scale_ack while scale_req=0 is ignored.
- OUT: addr runs 0..2**bit_isi+2**bit_addr-1 with out_valid=1.
  - addr advances only when out_valid and out_ready are both 1.
  - addr and out_valid are held while out_ready=0.
  - After the last transfer -> DONE.
- DONE: done=1 for one cycle, busy drops in the same cycle -> IDLE.
- addr is 0 in IDLE, CLR, SCALE and DONE. The counter must never wrap inside a phase.
- abort=1 in any state:
  - next cycle is IDLE with all strobes 0 and done=0;
  - the wr_en pipeline is flushed, so no write-back follows an abort;
  - abort has priority over start when both are high in the same cycle.
- Sweep ends are exact: the last rd_en is at the max address. The last wr_en is RD_LAT cycles later, inside DRAIN.

Decomposition:
- Shared package landscape_pkg:
  - phase code constants;
  - helper functions for N_SCALE, ADDR_W, sweep lengths and the window-length formula, so the window controller and this block agree.
- One sub-module, lsp_delay_line: an RD_LAT-deep shift register for {wr_en, wr_addr} with synchronous flush and async active-low reset.

Test Plan:
Test parameters: bit_isi=2, bit_addr=2, sb_r_min=3, RD_LAT=3, so N_SCALE=2.
1. Full run, scale_ack tied 1, out_ready tied 1, start pulse at cycle 0 -> phases 1,2(4 cycles + 3 drain),3(16+3),4(2 steps),5(8 words),6. done pulses exactly once; busy falls in the same cycle.
2. Write-back timing, same run -> wr_en high for exactly 4 cycles starting 3 cycles after the first hist rd_en, with wr_addr 0,1,2,3; same pattern for pair with 16 writes, addr 0..15.
3. out_ready toggled 1,0,0,1,... during OUT -> addr holds while out_ready=0; exactly 8 transfers, addr 0..7 in order; no duplicates or skips.
4. scale_ack delayed 5 cycles per step -> scale_idx stays 0 for 6 cycles, then 1; OUT entered only after the second ack.
5. abort mid-PAIR at addr 7 -> next cycle phase=0, rd_en=wr_en=0, busy=0, done never asserted; a fresh start then runs the full sequence correctly.
6. start asserted during HIST, and start+abort together in IDLE -> mid-run start ignored (sequence unchanged); simultaneous start+abort leaves the block in IDLE.

Source files
------------

// File: rtl/landscape_pkg.sv
// Shared constants and sizing helpers for the landscape-sampling datapath.
// The window controller and the phase sequencer both size themselves from these helpers.
package landscape_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_CLR   = 3'd1,
    PH_HIST  = 3'd2,
    PH_PAIR  = 3'd3,
    PH_SCALE = 3'd4,
    PH_OUT   = 3'd5,
    PH_DONE  = 3'd6
  } phase_e;

  function automatic int n_scale(input int bit_addr, input int sb_r_min);
    return 2 * bit_addr - sb_r_min + 1;
  endfunction

  function automatic int addr_w(input int bit_isi, input int bit_addr);
    int w;
    w = 2 * bit_addr;
    if (bit_isi + 1 > w) w = bit_isi + 1;
    if (bit_addr + 1 > w) w = bit_addr + 1;
    return w;
  endfunction

  function automatic int scale_idx_w(input int bit_addr, input int sb_r_min);
    return $clog2(n_scale(bit_addr, sb_r_min) + 1);
  endfunction

  function automatic int hist_len(input int bit_isi);
    return 1 << bit_isi;
  endfunction

  function automatic int pair_len(input int bit_addr);
    return 1 << (2 * bit_addr);
  endfunction

  function automatic int out_len(input int bit_isi, input int bit_addr);
    return (1 << bit_isi) + (1 << bit_addr);
  endfunction

  // Start-to-done cycle count when scale_ack and out_ready never stall.
  function automatic int window_len(input int bit_isi, input int bit_addr,
                                    input int sb_r_min, input int rd_lat);
    return 1 + hist_len(bit_isi) + rd_lat + pair_len(bit_addr) + rd_lat +
           n_scale(bit_addr, sb_r_min) + out_len(bit_isi, bit_addr) + 1;
  endfunction

endpackage

// File: rtl/lsp_delay_line.sv
// Fixed-depth shift register carrying the write-back strobe and address.
// A flush clears every stage so nothing in flight emerges afterwards.
module lsp_delay_line #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  typedef logic [DEPTH-1:0][WIDTH-1:0] stage_t;

  stage_t stage_q;
  stage_t stage_d;

  // The cast drops the oldest stage off the top of the concatenation.
  always_comb begin
    stage_d = '0;
    if (!flush) stage_d = stage_t'({stage_q, din});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/landscape_phase_seq.sv
// Post-recording processing sequencer: clear, histogram sweep, pair sweep,
// scale steps and read-out, with RAM strobes and handshakes. All outputs registered.
module landscape_phase_seq
  import landscape_pkg::*;
#(
  parameter int bit_isi  = 8,
  parameter int bit_addr = 9,
  parameter int sb_r_min = 3,
  parameter int RD_LAT   = 3
) (
  input  logic                                         clk_main,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic                                         abort,
  input  logic                                         scale_ack,
  input  logic                                         out_ready,
  output logic                                         busy,
  output logic [2:0]                                   phase,
  output logic [addr_w(bit_isi, bit_addr)-1:0]         addr,
  output logic                                         rd_en,
  output logic                                         wr_en,
  output logic [addr_w(bit_isi, bit_addr)-1:0]         wr_addr,
  output logic                                         clr_acc,
  output logic                                         scale_req,
  output logic [scale_idx_w(bit_addr, sb_r_min)-1:0]   scale_idx,
  output logic                                         out_valid,
  output logic                                         done
);

  localparam int AW = addr_w(bit_isi, bit_addr);
  localparam int SW = scale_idx_w(bit_addr, sb_r_min);
  localparam int NS = n_scale(bit_addr, sb_r_min);
  localparam int DW = $clog2(RD_LAT + 1);

  localparam logic [AW-1:0] HIST_LAST  = AW'(hist_len(bit_isi) - 1);
  localparam logic [AW-1:0] PAIR_LAST  = AW'(pair_len(bit_addr) - 1);
  localparam logic [AW-1:0] OUT_LAST   = AW'(out_len(bit_isi, bit_addr) - 1);
  localparam logic [SW-1:0] SCALE_LAST = SW'(NS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLR, ST_HIST, ST_DRAIN, ST_PAIR, ST_SCALE, ST_OUT, ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   k_q, k_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            after_pair_q, after_pair_d;

  phase_e          phase_q, phase_d;
  logic            busy_q, busy_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_en_q, rd_en_d;
  logic            clr_acc_q, clr_acc_d;
  logic            scale_req_q, scale_req_d;
  logic [SW-1:0]   scale_idx_q, scale_idx_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    k_d          = k_q;
    dcnt_d       = dcnt_q;
    after_pair_d = after_pair_q;
    if (abort) begin
      state_d      = ST_IDLE;
      cnt_d        = '0;
      k_d          = '0;
      dcnt_d       = '0;
      after_pair_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) state_d = ST_CLR;
        ST_CLR: begin
          state_d = ST_HIST;
          cnt_d   = '0;
        end
        ST_HIST: begin
          if (cnt_q == HIST_LAST) begin
            state_d      = ST_DRAIN;
            cnt_d        = '0;
            dcnt_d       = '0;
            after_pair_d = 1'b0;
          end else cnt_d = cnt_q + AW'(1);
        end
        // One drain state serves both sweeps; after_pair picks the successor.
        ST_DRAIN: begin
          if (dcnt_q == DRAIN_LAST) begin
            state_d = after_pair_q ? ST_SCALE : ST_PAIR;
            dcnt_d  = '0;
            k_d     = '0;
          end else dcnt_d = dcnt_q + DW'(1);
        end
        ST_PAIR: begin
          if (cnt_q == PAIR_LAST) begin
            state_d      = ST_DRAIN;
            cnt_d        = '0;
            dcnt_d       = '0;
            after_pair_d = 1'b1;
          end else cnt_d = cnt_q + AW'(1);
        end
        ST_SCALE: begin
          if (scale_req_q && scale_ack) begin
            if (k_q == SCALE_LAST) begin
              state_d = ST_OUT;
              k_d     = '0;
              cnt_d   = '0;
            end else k_d = k_q + SW'(1);
          end
        end
        ST_OUT: begin
          if (out_valid_q && out_ready) begin
            if (cnt_q == OUT_LAST) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else cnt_d = cnt_q + AW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in flops aligned with it.
  always_comb begin
    phase_d     = PH_IDLE;
    busy_d      = 1'b0;
    addr_d      = '0;
    rd_en_d     = 1'b0;
    clr_acc_d   = 1'b0;
    scale_req_d = 1'b0;
    scale_idx_d = '0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    unique case (state_d)
      ST_CLR: begin
        phase_d   = PH_CLR;
        busy_d    = 1'b1;
        clr_acc_d = 1'b1;
      end
      ST_HIST: begin
        phase_d = PH_HIST;
        busy_d  = 1'b1;
        addr_d  = cnt_d;
        rd_en_d = 1'b1;
      end
      ST_DRAIN: begin
        phase_d = after_pair_d ? PH_PAIR : PH_HIST;
        busy_d  = 1'b1;
      end
      ST_PAIR: begin
        phase_d = PH_PAIR;
        busy_d  = 1'b1;
        addr_d  = cnt_d;
        rd_en_d = 1'b1;
      end
      ST_SCALE: begin
        phase_d     = PH_SCALE;
        busy_d      = 1'b1;
        scale_req_d = 1'b1;
        scale_idx_d = k_d;
      end
      ST_OUT: begin
        phase_d     = PH_OUT;
        busy_d      = 1'b1;
        addr_d      = cnt_d;
        out_valid_d = 1'b1;
      end
      ST_DONE: begin
        phase_d = PH_DONE;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      k_q          <= '0;
      dcnt_q       <= '0;
      after_pair_q <= 1'b0;
      phase_q      <= PH_IDLE;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      clr_acc_q    <= 1'b0;
      scale_req_q  <= 1'b0;
      scale_idx_q  <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      dcnt_q       <= dcnt_d;
      after_pair_q <= after_pair_d;
      phase_q      <= phase_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      clr_acc_q    <= clr_acc_d;
      scale_req_q  <= scale_req_d;
      scale_idx_q  <= scale_idx_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
    end
  end

  logic [AW:0] wb_q;

  lsp_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (AW + 1)
  ) u_wb_delay (
    .clk   (clk_main),
    .rst_n (rst_n),
    .flush (abort),
    .din   ({rd_en_q, addr_q}),
    .dout  (wb_q)
  );

  assign {wr_en, wr_addr} = wb_q;
  assign busy      = busy_q;
  assign phase     = phase_q;
  assign addr      = addr_q;
  assign rd_en     = rd_en_q;
  assign clr_acc   = clr_acc_q;
  assign scale_req = scale_req_q;
  assign scale_idx = scale_idx_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule
